// File: rtl/mic_microsequencer.sv
// Microprogram sequencer: owns the MPC and forms the next microaddress
// from next_address, JAM bits, ALU flags and MBR, with start/halt/stall.
// Ports:
//   clock, reset (sync, active-high), start
//   next_address[8:0], jam[2:0] {JMPC,JAMN,JAMZ}, alu_n, alu_z, mbr[7:0]
//   mem_busy
//   mpc[8:0], mir_load, running, halted, n_flag, z_flag
//   step_count[CNT_W-1:0]
module mic_microsequencer #(
  parameter logic [8:0] START_ADDR = 9'h000,
  parameter logic [8:0] HALT_ADDR  = 9'h1FF,
  parameter int         CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [8:0]       next_address,
  input  logic [2:0]       jam,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic [7:0]       mbr,
  input  logic             mem_busy,
  output logic [8:0]       mpc,
  output logic             mir_load,
  output logic             running,
  output logic             halted,
  output logic             n_flag,
  output logic             z_flag,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL,
    HALTED
  } state_t;

  state_t     state;
  logic       hi;
  logic [7:0] lo;
  logic [8:0] nxt;

  // JAMN and JAMZ both feed bit 8; JMPC ORs the whole MBR byte.
  always_comb begin
    hi  = next_address[8]
        | (jam[1] & alu_n)
        | (jam[0] & alu_z);
    lo  = next_address[7:0]
        | (jam[2] ? mbr : 8'h00);
    nxt = {hi, lo};
  end

  // Only output allowed to see the inputs combinationally.
  assign mir_load = (state == RUN) & ~mem_busy;
  assign running  = (state == RUN) | (state == STALL);
  assign halted   = (state == HALTED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      mpc        <= START_ADDR;
      n_flag     <= 1'b0;
      z_flag     <= 1'b0;
      step_count <= '0;
    end else begin
      unique case (state)
        IDLE, HALTED: begin
          if (start) begin
            state      <= RUN;
            mpc        <= START_ADDR;
            step_count <= '0;
          end
        end
        RUN: begin
          if (mem_busy) begin
            state <= STALL;
          end else begin
            mpc    <= nxt;
            n_flag <= alu_n;
            z_flag <= alu_z;
            if (!(&step_count))
              step_count <= step_count + 1'b1;
            if (nxt == HALT_ADDR)
              state <= HALTED;
          end
        end
        STALL: begin
          // Held microinstruction re-executes once back in RUN.
          if (!mem_busy)
            state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mic_microsequencer.sv
// Self-checking bench for mic_microsequencer: directed scenarios with
// literal expectations, then random stimulus against a behavioural model.
module tb_mic_microsequencer;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [8:0]       next_address;
  logic [2:0]       jam;
  logic             alu_n;
  logic             alu_z;
  logic [7:0]       mbr;
  logic             mem_busy;
  logic [8:0]       mpc;
  logic             mir_load;
  logic             running;
  logic             halted;
  logic             n_flag;
  logic             z_flag;
  logic [CNT_W-1:0] step_count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  mic_microsequencer #(
    .START_ADDR(9'h000),
    .HALT_ADDR (9'h1FF),
    .CNT_W     (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .next_address(next_address),
    .jam         (jam),
    .alu_n       (alu_n),
    .alu_z       (alu_z),
    .mbr         (mbr),
    .mem_busy    (mem_busy),
    .mpc         (mpc),
    .mir_load    (mir_load),
    .running     (running),
    .halted      (halted),
    .n_flag      (n_flag),
    .z_flag      (z_flag),
    .step_count  (step_count)
  );

  always #5 clock = ~clock;

  // Behavioural model: mode 0=idle 1=executing 2=waiting on memory 3=halted
  int m_mode = 0;
  int m_mpc  = 0;
  int m_n    = 0;
  int m_z    = 0;
  int m_step = 0;

  always @(posedge clock) begin
    int target;
    if (reset) begin
      m_mode = 0; m_mpc = 0; m_n = 0; m_z = 0; m_step = 0;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (start) begin
        m_mode = 1; m_mpc = 0; m_step = 0;
      end
    end else if (m_mode == 2) begin
      if (!mem_busy) m_mode = 1;
    end else if (mem_busy) begin
      m_mode = 2;
    end else begin
      target = int'(next_address);
      if ((jam[1] && alu_n) || (jam[0] && alu_z)) target = target | 256;
      if (jam[2]) target = target | int'(mbr);
      m_mpc = target;
      m_n = int'(alu_n);
      m_z = int'(alu_z);
      if (m_step < CMAX) m_step = m_step + 1;
      if (target == 511) m_mode = 3;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("mpc", 32'(mpc), 32'(m_mpc));
      check("running", 32'(running), 32'(m_mode == 1 || m_mode == 2));
      check("halted", 32'(halted), 32'(m_mode == 3));
      check("n_flag", 32'(n_flag), 32'(m_n));
      check("z_flag", 32'(z_flag), 32'(m_z));
      check("step_count", 32'(step_count), 32'(m_step));
      check("mir_load", 32'(mir_load), 32'(m_mode == 1 && !mem_busy));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [8:0] na, input logic [2:0] j,
                       input logic n, input logic z, input logic [7:0] b,
                       input logic busy);
    next_address = na; jam = j; alu_n = n; alu_z = z;
    mbr = b; mem_busy = busy;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    drive(9'h000, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0);
    tick(); tick();
    chk_en = 1'b1;
    reset = 1'b0;
    check("rst_mpc", 32'(mpc), 32'h000);
    check("rst_running", 32'(running), 32'h0);
    check("rst_step", 32'(step_count), 32'h0);

    start = 1'b1; tick(); start = 1'b0;
    check("start_mpc", 32'(mpc), 32'h000);
    check("start_running", 32'(running), 32'h1);

    drive(9'h001, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    check("seq1", 32'(mpc), 32'h001);
    drive(9'h002, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    check("seq2", 32'(mpc), 32'h002);
    drive(9'h004, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    check("seq4", 32'(mpc), 32'h004);
    check("seq_step", 32'(step_count), 32'd3);

    drive(9'h005, 3'b001, 1'b0, 1'b1, 8'h00, 1'b0); tick();
    check("jamz_hit", 32'(mpc), 32'h105);
    check("jamz_flag", 32'(z_flag), 32'h1);
    drive(9'h005, 3'b001, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    check("jamz_miss", 32'(mpc), 32'h005);

    drive(9'h000, 3'b100, 1'b0, 1'b0, 8'hA7, 1'b0); tick();
    check("jmpc", 32'(mpc), 32'h0A7);
    drive(9'h100, 3'b110, 1'b1, 1'b0, 8'hA7, 1'b0); tick();
    check("jmpc_jamn", 32'(mpc), 32'h1A7);

    drive(9'h010, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0); tick();
    check("pre_stall", 32'(mpc), 32'h010);
    drive(9'h011, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1);
    tick(); tick(); tick();
    check("stall_mpc", 32'(mpc), 32'h010);
    check("stall_step", 32'(step_count), 32'd8);
    check("stall_load", 32'(mir_load), 32'h0);
    mem_busy = 1'b0; tick();
    check("resume_mpc", 32'(mpc), 32'h010);
    tick();
    check("post_stall", 32'(mpc), 32'h011);
    check("post_step", 32'(step_count), 32'd9);

    drive(9'h1FF, 3'b000, 1'b1, 1'b1, 8'h00, 1'b0); tick();
    check("halt", 32'(halted), 32'h1);
    check("halt_run", 32'(running), 32'h0);
    check("halt_mpc", 32'(mpc), 32'h1FF);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_run", 32'(running), 32'h1);
    check("restart_mpc", 32'(mpc), 32'h000);
    check("restart_step", 32'(step_count), 32'd0);

    drive(9'h020, 3'b000, 1'b0, 1'b0, 8'h00, 1'b1); tick();
    reset = 1'b1; start = 1'b1; tick();
    reset = 1'b0; start = 1'b0;
    check("rst_stall_run", 32'(running), 32'h0);
    check("rst_stall_n", 32'(n_flag), 32'h0);
    check("rst_stall_z", 32'(z_flag), 32'h0);
    check("rst_stall_mpc", 32'(mpc), 32'h000);

    start = 1'b1; tick(); start = 1'b0;
    drive(9'h001, 3'b000, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("saturate", 32'(step_count), 32'(CMAX));

    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 15) == 0);
      drive(9'($urandom_range(0, 511)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 63) == 0) next_address = 9'h1FF;
      tick();
    end

    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
